muldiv_sequencer: RTL and testbench

Multi-cycle controller for RV32M operations issued from the execute stage. Registers the four 16×16 partial products the execute stage produces, sums and sign-corrects them for MUL/MULH/MULHSU/MULHU, and runs an iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. While an operation is in flight it stalls the front of the pipeline, then returns a single-cycle result pulse to the EX/MEM boundary.

---
 rtl/muldiv_sequencer_if.sv | 38 +++
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Purpose: request/response bundle between the execute stage and the RV32M
//          multi-cycle sequencer.
// Signals:
//   req_valid_i   M-extension op present in EX
//   req_funct3_i  operation select (MUL..REMU)
//   req_rs1_i/req_rs2_i  raw operands
//   req_sign_i    {rs1[31], rs2[31]}
//   mul_part_i    16x16 partial products: [0] lo*lo, [1] hi1*lo2, [2] lo1*hi2, [3] hi*hi
//   flush_i       kill the in-flight op
//   stall_o       hold IF/ID/EX
//   done_o        one-cycle result pulse
//   result_o      result, held until next done
//   busy_o        sequencer not idle
interface muldiv_sequencer_if;
    logic             req_valid_i;
    logic [2:0]       req_funct3_i;
    logic [31:0]      req_rs1_i;
    logic [31:0]      req_rs2_i;
    logic [1:0]       req_sign_i;
    logic [3:0][31:0] mul_part_i;
    logic             flush_i;
    logic             stall_o;
    logic             done_o;
    logic [31:0]      result_o;
    logic             busy_o;

    modport master (
        output req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_sign_i,
               mul_part_i, flush_i,
        input  stall_o, done_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_sign_i,
               mul_part_i, flush_i,
        output stall_o, done_o, result_o, busy_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Purpose: multi-cycle RV32M controller. Sums and sign-corrects the four
//          16x16 partial products for MUL/MULH/MULHSU/MULHU and runs a
//          radix-2 restoring divider for DIV/DIVU/REM/REMU, stalling the
//          front of the pipeline while an op is in flight.
// Ports:
//   clk   clock, all state on rising edge
//   rstn  asynchronous active-low reset
//   bus   muldiv_sequencer_if.slave (request in, stall/done/result/busy out)
// Configuration:
//   MULDIV_DIV_EN  when defined, the divider datapath (DIV_RUN/DIV_FIX and
//                  divide special cases) is built; otherwise divide ops
//                  complete in one cycle with result 0.
module muldiv_sequencer (
    input logic               clk,
    input logic               rstn,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_ACC = 3'd1,
        DIV_RUN = 3'd2,
        DIV_FIX = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               r_state;
    logic [3:0][XLEN-1:0] r_part;
    logic [2:0]           r_funct3;
    logic [1:0]           r_sign;
    logic [XLEN-1:0]      r_result;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_accept;
    logic [2*XLEN-1:0]    w_prod_raw;
    logic [2*XLEN-1:0]    w_prod;
    logic                 w_prod_neg;

    assign w_accept = bus.req_valid_i && !bus.flush_i;

    // Full 64-bit sum of the partial products, then sign correction for the
    // ops whose operands EX magnitude-converted.
    assign w_prod_raw = (2*XLEN)'(r_part[0])
                      + ((2*XLEN)'(r_part[1]) << 16)
                      + ((2*XLEN)'(r_part[2]) << 16)
                      + ((2*XLEN)'(r_part[3]) << 32);
    assign w_prod_neg = ((r_funct3 == 3'b001) && (r_sign[1] ^ r_sign[0]))
                     || ((r_funct3 == 3'b010) && r_sign[1]);
    assign w_prod     = w_prod_neg ? -w_prod_raw : w_prod_raw;

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_dvs;
    logic [CNT_W-1:0] r_cnt;

    logic             w_div_signed;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [XLEN-1:0]  w_special;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_r_fix;

    // funct3[0]=0 selects the signed variants (DIV/REM).
    assign w_div_signed = !bus.req_funct3_i[0];
    assign w_mag1 = (w_div_signed && bus.req_sign_i[1]) ? -bus.req_rs1_i : bus.req_rs1_i;
    assign w_mag2 = (w_div_signed && bus.req_sign_i[0]) ? -bus.req_rs2_i : bus.req_rs2_i;
    assign w_div_zero = (bus.req_rs2_i == '0);
    assign w_div_ovf  = w_div_signed && (bus.req_rs1_i == 32'h8000_0000)
                     && (bus.req_rs2_i == 32'hFFFF_FFFF);

    // Architected results for divide-by-zero and signed overflow; funct3[1] picks remainder.
    always_comb begin
        w_special = '0;
        if (w_div_zero) begin
            w_special = bus.req_funct3_i[1] ? bus.req_rs1_i : 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
            w_special = bus.req_funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // One restoring step: bring the next dividend bit into the remainder and trial-subtract.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    assign w_q_fix = (!r_funct3[0] && (r_sign[1] ^ r_sign[0])) ? -r_quot : r_quot;
    assign w_r_fix = (!r_funct3[0] && r_sign[1]) ? -r_rem : r_rem;
`else
    logic w_unused_ops;
    assign w_unused_ops = ^{bus.req_rs1_i, bus.req_rs2_i};
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_part   <= '0;
            r_funct3 <= '0;
            r_sign   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (bus.flush_i) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.req_valid_i) begin
                            r_funct3 <= bus.req_funct3_i;
                            r_sign   <= bus.req_sign_i;
                            r_busy   <= 1'b1;
                            if (!bus.req_funct3_i[2]) begin
                                r_part  <= bus.mul_part_i;
                                r_state <= MUL_ACC;
`ifdef MULDIV_DIV_EN
                            end else if (w_div_zero || w_div_ovf) begin
                                r_result <= w_special;
                                r_done   <= 1'b1;
                                r_state  <= DONE;
                            end else begin
                                r_rem   <= '0;
                                r_quot  <= w_mag1;
                                r_dvs   <= w_mag2;
                                r_cnt   <= '0;
                                r_state <= DIV_RUN;
                            end
`else
                            end else begin
                                r_result <= '0;
                                r_done   <= 1'b1;
                                r_state  <= DONE;
                            end
`endif
                        end
                    end
                    MUL_ACC: begin
                        r_result <= (r_funct3 == 3'b000) ? w_prod[XLEN-1:0]
                                                         : w_prod[2*XLEN-1:XLEN];
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
`ifdef MULDIV_DIV_EN
                    DIV_RUN: begin
                        if (!w_diff[XLEN]) begin
                            r_rem  <= w_diff[XLEN-1:0];
                            r_quot <= {r_quot[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem  <= w_shift[XLEN-1:0];
                            r_quot <= {r_quot[XLEN-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(XLEN - 1)) begin
                            r_state <= DIV_FIX;
                        end
                    end
                    DIV_FIX: begin
                        r_result <= r_funct3[1] ? w_r_fix : w_q_fix;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
`endif
                    DONE: begin
                        // The finished instruction is still in EX this cycle; do not re-accept it.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stall must rise in the accept cycle itself, so it decodes the live request in IDLE.
    assign bus.stall_o  = rstn && (((r_state == IDLE) && w_accept)
                                   || (r_state == MUL_ACC)
                                   || (r_state == DIV_RUN)
                                   || (r_state == DIV_FIX));
    assign bus.done_o   = r_done;
    assign bus.busy_o   = r_busy;
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases plus randomized ops checked
// against an arithmetic reference model of RV32M results and latencies.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rstn;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RV32M architectural result.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      s1, s2, u1, u2;
        logic [63:0] p;
        int          sa, sb;
        logic        ovf;
        s1  = $signed(a);
        s2  = $signed(b);
        u1  = {32'b0, a};
        u2  = {32'b0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = 64'(u1 * u2); return p[31:0]; end
            3'd1: begin p = 64'(s1 * s2); return p[63:32]; end
            3'd2: begin p = 64'(s1 * u2); return p[63:32]; end
            3'd3: begin p = 64'(u1 * u2); return p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            3'd7: return (b == 0) ? a : a % b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Cycles from the accept cycle to the done_o cycle.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
`ifdef MULDIV_DIV_EN
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
`else
        return 1;
`endif
    endfunction

    // Plays the role of EX: magnitude conversion and 16x16 partial products.
    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = ((f3 == 3'd1 || f3 == 3'd2) && a[31]) ? -a : a;
        mb = ((f3 == 3'd1) && b[31]) ? -b : b;
        bus.mul_part_i[0] = 32'(ma[15:0])  * 32'(mb[15:0]);
        bus.mul_part_i[1] = 32'(ma[31:16]) * 32'(mb[15:0]);
        bus.mul_part_i[2] = 32'(ma[15:0])  * 32'(mb[31:16]);
        bus.mul_part_i[3] = 32'(ma[31:16]) * 32'(mb[31:16]);
        bus.req_sign_i    = {a[31], b[31]};
        bus.req_funct3_i  = f3;
        bus.req_rs1_i     = a;
        bus.req_rs2_i     = b;
        bus.flush_i       = 1'b0;
        bus.req_valid_i   = 1'b1;
    endtask

    // Issue one op in the current cycle (N) and follow it to done_o; returns in the done cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          exp_lat, lat;
        logic [31:0] exp_res;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        drive_req(f3, a, b);
        #1;
        check_eq("stall_accept", 32'(bus.stall_o), 32'd1);
        lat = 0;
        do begin
            tick();
            lat++;
            if (!bus.done_o && lat == 1) begin
                check_eq("busy_inflight", 32'(bus.busy_o), 32'd1);
                check_eq("stall_inflight", 32'(bus.stall_o), 32'd1);
            end
        end while (!bus.done_o && lat < 40);
        check_eq($sformatf("latency_f%0d", f3), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("result_f%0d_%08h_%08h", f3, a, b), bus.result_o, exp_res);
        check_eq("stall_done", 32'(bus.stall_o), 32'd0);
        last_res = exp_res;
    endtask

    // Leave the DONE cycle with the old request still asserted; it must not re-issue.
    task automatic after_done();
        tick();
        check_eq("no_reissue", 32'(bus.done_o), 32'd0);
        check_eq("idle_after_done", 32'(bus.busy_o), 32'd0);
        check_eq("result_hold", bus.result_o, last_res);
    endtask

    // Issue an op and flush it in cycle N+k; returns in cycle N+k+1.
    task automatic flush_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input int k);
        drive_req(f3, a, b);
        #1;
        check_eq("flush_stall_accept", 32'(bus.stall_o), 32'd1);
        for (int i = 0; i < k; i++) begin
            tick();
            check_eq("flush_pre_done", 32'(bus.done_o), 32'd0);
        end
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b0;
        tick();
        bus.flush_i = 1'b0;
        check_eq("flush_busy", 32'(bus.busy_o), 32'd0);
        check_eq("flush_stall", 32'(bus.stall_o), 32'd0);
        check_eq("flush_done", 32'(bus.done_o), 32'd0);
        check_eq("flush_result", bus.result_o, last_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          mode, gap;

        rstn             = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.req_sign_i   = '0;
        bus.mul_part_i   = '0;
        bus.flush_i      = 1'b0;
        last_res         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall", 32'(bus.stall_o), 32'd0);
        check_eq("rst_done", 32'(bus.done_o), 32'd0);
        check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("rst_result", bus.result_o, 32'd0);
        bus.req_valid_i = 1'b0;
        rstn            = 1'b1;
        tick();

        // Directed cases, back to back.
        do_op(3'd0, 32'd7, 32'd6);                     after_done();
        do_op(3'd1, 32'hFFFF_FFFD, 32'd5);             after_done();
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);     after_done();
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);     after_done();
        do_op(3'd5, 32'd100, 32'd7);                   after_done();
        do_op(3'd7, 32'd100, 32'd7);                   after_done();
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);             after_done();
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);             after_done();
        do_op(3'd4, 32'd5, 32'd0);                     after_done();
        do_op(3'd6, 32'd5, 32'd0);                     after_done();
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);     after_done();
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);     after_done();
        do_op(3'd0, 32'd9, 32'd5);                     after_done();

        // Flush during multiply, then an op issued in the very next cycle.
        flush_op(3'd0, 32'd11, 32'd13, 1);
        do_op(3'd0, 32'd3, 32'd3);                     after_done();
`ifdef MULDIV_DIV_EN
        flush_op(3'd5, 32'd100, 32'd7, 10);
        do_op(3'd0, 32'd3, 32'd3);                     after_done();
`endif

        // Flush and request in the same idle cycle: flush wins.
        drive_req(3'd0, 32'd7, 32'd6);
        bus.flush_i = 1'b1;
        #1;
        check_eq("flush_vs_accept_stall", 32'(bus.stall_o), 32'd0);
        tick();
        check_eq("flush_vs_accept_busy", 32'(bus.busy_o), 32'd0);
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        tick();
        check_eq("flush_vs_accept_done", 32'(bus.done_o), 32'd0);

        // Reset in the middle of an op with a nonzero result already held.
        do_op(3'd0, 32'd7, 32'd6);
        after_done();
        drive_req(3'd5, 32'd100, 32'd7);
        tick();
`ifdef MULDIV_DIV_EN
        repeat (4) tick();
`endif
        rstn = 1'b0;
        #1;
        check_eq("midrst_stall", 32'(bus.stall_o), 32'd0);
        check_eq("midrst_done", 32'(bus.done_o), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("midrst_result", bus.result_o, 32'd0);
        tick();
        bus.req_valid_i = 1'b0;
        rstn            = 1'b1;
        last_res        = '0;
        tick();
        check_eq("postrst_busy", 32'(bus.busy_o), 32'd0);

        // Randomized ops with corner-biased operands and random idle gaps.
        for (int n = 0; n < 40; n++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
                3: begin a = -32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(f3, a, b);
            after_done();
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                bus.req_valid_i = 1'b0;
                repeat (gap) tick();
            end
        end
        bus.req_valid_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
